serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor_full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions: FSM state encodings and counter sizing helper
// for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full-subtractor cell: d = x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell and a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;

  full_subtractor u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_next)
  );

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (r_cnt == LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_br  <= w_br_next;
      r_cnt <= r_cnt + 1'b1;
      // The last bit goes straight into the held result so it is valid in DONE.
      if (w_last) begin
        r_diff <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_br_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand MSBs are shifted away during RUN, so keep copies for the overflow test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor; ovf checks compiled in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] last_diff = '0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int  n;
    logic seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    check("busy_run", 32'(bus.busy), 32'd1);
    check("diff_hold_start", 32'(bus.diff), 32'(last_diff));
    n = 0;
    seen = 1'b0;
    while (n < 3 * W && !seen) begin
      @(negedge clk);
      n++;
      if (n == W / 2) check("diff_hold_mid", 32'(bus.diff), 32'(last_diff));
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), 32'(W));
    check("diff", 32'(bus.diff), 32'(ed));
    check("bout", 32'(bus.bout), 32'(eb));
    check("busy_done", 32'(bus.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(bus.ovf), 32'(eo));
`endif
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("diff_after", 32'(bus.diff), 32'(ed));
    last_diff = ed;
    $display("op a=%02h b=%02h -> diff=%02h bout=%0d (exp %02h/%0d ovf %0d) lat=%0d",
             a, b, bus.diff, bus.bout, ed, eb, eo, n);
  endtask

  logic [W-1:0] ca  [3] = '{8'h50, 8'h10, 8'h7F};
  logic [W-1:0] cb  [3] = '{8'h20, 8'h7F, 8'h80};
  logic [W-1:0] cd  [3] = '{8'h30, 8'h91, 8'hFF};
  logic         cbo [3] = '{1'b0, 1'b1, 1'b1};
  logic         co  [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

    // start held high; only operands present at accepting edges matter
    @(negedge clk);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 10 == 0) begin
        bus.a = ca[k / 10];
        bus.b = cb[k / 10];
      end else begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("cont_busy", 32'(bus.busy), 32'((k % 10) < 8));
      check("cont_done", 32'(bus.done), 32'((k % 10) == 8));
      if (bus.done) begin
        check("cont_diff", 32'(bus.diff), 32'(cd[k / 10]));
        check("cont_bout", 32'(bus.bout), 32'(cbo[k / 10]));
`ifdef SERIAL_SUB_OVF_EN
        check("cont_ovf", 32'(bus.ovf), 32'(co[k / 10]));
`endif
        $display("cont op %0d a=%02h b=%02h -> diff=%02h bout=%0d ovf_exp=%0d",
                 k / 10, ca[k / 10], cb[k / 10], bus.diff, bus.bout, co[k / 10]);
        ndone++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("cont_ndone", 32'(ndone), 32'd3);
    last_diff = cd[2];

    // reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h35;
    bus.b = 8'h12;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_bout", 32'(bus.bout), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("mid_rst_nodone", 32'(ndone), 32'd0);
    $display("reset mid-op: busy=%0d diff=%02h", bus.busy, bus.diff);
    last_diff = '0;
    run_op(8'hC8, 8'h3C, 8'h8C, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
